// File: rtl/turbo_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : turbo_enc_ctrl
// Purpose  : Block sequencer for the turbo encoder (encode / overlap / tail).
// Revision : 1.0
// ============================================================================
module turbo_enc_ctrl #(
    parameter int LEN_W   = 14,
    parameter int TAIL    = 3,
    parameter int MIN_LEN = TAIL + 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_valid,
    input  logic [LEN_W-1:0] blk_len,
    output logic             start_ready,
    output logic             enable,
    output logic             trellis_enable,
    output logic             switch,
    output logic             clr,
    output logic             trl_clr,
    output logic             mod_clr,
    output logic [2:0]       current_state,
    output logic [LEN_W-1:0] bit_cnt,
    output logic             blk_done,
    output logic [CNT_W-1:0] blk_count,
    output logic             len_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_OVERLAP = 3'd1;
    localparam logic [2:0] S_TAIL    = 3'd2;
    localparam logic [2:0] S_ENCODE  = 3'd3;

    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
    localparam logic [LEN_W-1:0] TAIL_LAST = LEN_W'(TAIL - 1);
    localparam logic [LEN_W-1:0] TAIL_CNT  = LEN_W'(TAIL);
    localparam logic [LEN_W-1:0] MIN_L     = LEN_W'(MIN_LEN);

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             enable_q, enable_d;
    logic             te_q, te_d;
    logic             switch_q, switch_d;
    logic             clr_q, clr_d;
    logic             trl_clr_q, trl_clr_d;
    logic             mod_clr_q, mod_clr_d;
    logic             done_q, done_d;

    logic w_last_bit;
    logic w_tail_last;
    logic w_accept;
    logic w_short;

    assign w_last_bit  = (cnt_q == (len_q - ONE));
    assign w_tail_last = (cnt_q == TAIL_LAST);
    assign start_ready = (state_q == S_IDLE) || ((state_q == S_ENCODE) && w_last_bit);
    assign w_accept    = data_valid && start_ready;
    assign w_short     = (blk_len < MIN_L);

    // State register plus all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= MIN_L;
            count_q   <= '0;
            err_q     <= 1'b0;
            enable_q  <= 1'b0;
            te_q      <= 1'b0;
            switch_q  <= 1'b0;
            clr_q     <= 1'b1;
            trl_clr_q <= 1'b1;
            mod_clr_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            count_q   <= count_d;
            err_q     <= err_d;
            enable_q  <= enable_d;
            te_q      <= te_d;
            switch_q  <= switch_d;
            clr_q     <= clr_d;
            trl_clr_q <= trl_clr_d;
            mod_clr_q <= mod_clr_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_ENCODE;
                end
            end
            S_ENCODE: begin
                if (!w_last_bit) begin
                    state_d = S_ENCODE;
                    cnt_d   = cnt_q + ONE;
                end else if (w_accept) begin
                    state_d = S_OVERLAP;
                end else begin
                    state_d = S_TAIL;
                end
            end
            S_OVERLAP: begin
                // New block has been encoding since the overlap began
                if (w_tail_last) begin
                    state_d = S_ENCODE;
                    cnt_d   = TAIL_CNT;
                end else begin
                    state_d = S_OVERLAP;
                    cnt_d   = cnt_q + ONE;
                end
            end
            S_TAIL: begin
                if (!w_tail_last) begin
                    state_d = S_TAIL;
                    cnt_d   = cnt_q + ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        len_d     = w_accept ? (w_short ? MIN_L : blk_len) : len_q;
        err_d     = err_q || (w_accept && w_short);
        enable_d  = (state_d == S_ENCODE) || (state_d == S_OVERLAP);
        switch_d  = (state_d == S_OVERLAP) || (state_d == S_TAIL);
        clr_d     = (state_d == S_IDLE) || (state_d == S_TAIL);
        mod_clr_d = (state_q == S_ENCODE) && (state_d == S_OVERLAP);
        done_d    = ((state_q == S_OVERLAP) && (state_d == S_ENCODE)) ||
                    ((state_q == S_TAIL) && (state_d == S_IDLE));
        trl_clr_d = (state_d == S_IDLE) || ((state_q == S_OVERLAP) && (state_d == S_ENCODE));
        te_d      = (state_d == S_ENCODE) && (cnt_d == (len_d - ONE));
        count_d   = count_q + CNT_W'(done_d);
    end

    assign enable         = enable_q;
    assign trellis_enable = te_q;
    assign switch         = switch_q;
    assign clr            = clr_q;
    assign trl_clr        = trl_clr_q;
    assign mod_clr        = mod_clr_q;
    assign current_state  = state_q;
    assign bit_cnt        = cnt_q;
    assign blk_done       = done_q;
    assign blk_count      = count_q;
    assign len_err        = err_q;

endmodule
`default_nettype wire

// File: doc/turbo_enc_ctrl.md
Name: turbo_enc_ctrl

Overview:
- Parametrised control FSM for the turbo encoder datapath.
- Sequences each block through encode, trellis termination and clear phases, driving the constituent encoders, interleaver and trellis-termination mux.
- Generalises the fixed two-length controller:
  - block length is a runtime port, latched per block;
  - tail length is a parameter;
  - back-to-back blocks overlap the tail of block N with the head of block N+1;
  - adds block-done, completed-block count and length-error reporting.

Parameters:
- LEN_W, 14, width of block length and bit counter
- TAIL, 3, trellis termination cycles (encoder memory depth)
- MIN_LEN, TAIL+2, smallest legal block length; must exceed TAIL+1
- CNT_W, 16, width of completed-block counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data_valid  in  1  input block present; sampled only when start_ready=1
- blk_len  in  LEN_W  block length L; latched when a block start is accepted
- start_ready  out  1  controller can accept a block start this cycle
- enable  out  1  encoders consume input bits
- trellis_enable  out  1  last data bit of the current block is being encoded
- switch  out  1  termination mux selects trellis feedback (tail active)
- clr  out  1  clear encoder registers
- trl_clr  out  1  clear termination-bit buffer
- mod_clr  out  1  clear interleaver/modulo address for a new overlapped block
- current_state  out  3  IDLE=0, OVERLAP=1, TAIL=2, ENCODE=3
- bit_cnt  out  LEN_W  bit index within the current phase
- blk_done  out  1  one-cycle pulse per completed block
- blk_count  out  CNT_W  completed blocks, wraps modulo 2^CNT_W
- len_err  out  1  sticky: a latched blk_len was below MIN_LEN

Behaviour:
- All outputs are registered. Reset takes effect at the next edge and overrides everything.
- Reset values:
  - state=IDLE, bit_cnt=0, blk_count=0, len_err=0
  - clr=1, trl_clr=1
  - enable=0, trellis_enable=0, switch=0, mod_clr=0, blk_done=0
- start_ready is combinational from state: 1 in IDLE, and in ENCODE when bit_cnt==L-1; else 0.
- Accept = data_valid & start_ready. On accept:
  - L <= max(blk_len, MIN_LEN);
  - len_err <= 1 if blk_len < MIN_LEN.
- blk_len is ignored at all other times.
- IDLE:
  - clr=1, trl_clr=1, enable=0.
  - On accept: next state ENCODE, bit_cnt=0, enable=1, clr=0, trl_clr=0.
- ENCODE:
  - bit_cnt increments each cycle while < L-1.
  - trellis_enable=1 exactly during the cycle with bit_cnt==L-1 (registered set when bit_cnt==L-2).
  - At bit_cnt==L-1 with accept: next state OVERLAP, bit_cnt=0, switch=1, enable stays 1, mod_clr=1 for one cycle.
  - At bit_cnt==L-1 without accept: next state TAIL, bit_cnt=0, enable=0, switch=1, clr=1.
- OVERLAP (tail of block N runs while block N+1 encodes):
  - Lasts exactly TAIL cycles, bit_cnt 0..TAIL-1, enable=1, switch=1.
  - After the bit_cnt==TAIL-1 cycle: next state ENCODE, bit_cnt=TAIL (counting continues within block N+1), switch=0, trl_clr=1 for one cycle, blk_done=1 for one cycle, blk_count+1.
  - MIN_LEN guarantees bit_cnt==L-1 is never reached inside OVERLAP.
- TAIL:
  - Lasts exactly TAIL cycles, bit_cnt 0..TAIL-1, switch=1, enable=0, clr=1.
  - After the bit_cnt==TAIL-1 cycle: next state IDLE, bit_cnt=0, switch=0, trl_clr=1, blk_done=1 (one cycle), blk_count+1.
  - clr stays 1 in IDLE.
- data_valid outside an accept window has no effect.
- blk_len changes mid-block have no effect.
- Reset mid-block returns to IDLE with no blk_done pulse; blk_count and len_err clear.
- blk_count wraps from 2^CNT_W-1 to 0 with no flag.
- No encoding of current_state other than IDLE/OVERLAP/TAIL/ENCODE is reachable. If an illegal state value is ever present, the next state is IDLE.

Test Plan:
1. Single block, TAIL=3, blk_len=6, data_valid high only in cycle t0 -> ENCODE t0+1..t0+6 (enable=1, bit_cnt 0..5); trellis_enable=1 only at t0+6; TAIL t0+7..t0+9 (switch=1, enable=0); IDLE at t0+10 with blk_done=1, blk_count=1.
2. Back-to-back, blk_len=6 then 8, data_valid held high at the t0+6 boundary -> OVERLAP t0+7..t0+9 with enable=1, switch=1; mod_clr=1 only at t0+7; ENCODE resumes t0+10 with bit_cnt=3, blk_done=1, trl_clr=1; second block ends with bit_cnt=7 at t0+14; then TAIL; blk_count=2.
3. Length clamp, blk_len=2 -> L=5: ENCODE lasts 5 cycles, len_err=1 and stays 1 through a later legal block until reset.
4. Reset asserted at ENCODE bit_cnt=3 -> next cycle state=0, enable=0, clr=1, trl_clr=1, bit_cnt=0, blk_count=0; no blk_done.
5. CNT_W=2, five single blocks of blk_len=5 -> blk_count 1,2,3,0,1; exactly one blk_done pulse per block.
6. data_valid pulsed during ENCODE bit_cnt=2 and during TAIL -> ignored: start_ready=0 in those cycles, no state change, no mod_clr.
